// File: rtl/cga_text_fetch.sv
// CGA text-mode character fetch and pixel serializer: reads char/attr from VRAM,
// looks up the glyph row in the font ROM and shifts out 4-bit colour indices.
module cga_text_fetch #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  char_start,
    input  logic [13:0]           crtc_ma,
    input  logic [4:0]            crtc_ra,
    input  logic                  display_en,
    input  logic                  cursor,
    input  logic                  blink_en,
    input  logic                  blink_phase,
    input  logic                  pixel_ce,
    output logic                  vram_en,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    input  logic [7:0]            vram_data,
    output logic                  font_en,
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [3:0]            pix_color,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    typedef enum logic [2:0] {IDLE, RD_CHAR, RD_ATTR, RD_FONT, CAPTURE} state_t;
    state_t state, state_next;

    logic [13:0] ma_p0;
    logic [2:0]  ra_p0;
    logic        en_p0, cur_p0;
    logic [7:0]  attr_p0;

    logic [7:0]  bmp_p1, attr_p1;
    logic        en_p1, cur_p1, vld_p1;

    logic [7:0]  shift_p2, attr_p2;
    logic        en_p2, cur_p2;

    logic [13:0] ma_src;
    logic [7:0]  ld_bmp, ld_attr, eff_bmp, eff_attr;
    logic        ld_en, ld_cur, eff_en, eff_cur;
    logic        unused_ra;

    assign unused_ra = ^crtc_ra[4:3];

    function automatic logic [3:0] pixel_color(input logic       b,
                                               input logic       cur,
                                               input logic [7:0] attr,
                                               input logic       en,
                                               input logic       blink,
                                               input logic       phase);
        logic       bit_on;
        logic [3:0] bg;
        bit_on = b | cur;
        if (blink && attr[7] && phase)
            bit_on = cur;
        bg = blink ? {1'b0, attr[6:4]} : attr[7:4];
        if (!en)
            return 4'd0;
        return bit_on ? attr[3:0] : bg;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            RD_CHAR: state_next = RD_ATTR;
            RD_ATTR: state_next = RD_FONT;
            RD_FONT: state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (char_start)
            state_next = RD_CHAR;
    end

    always_comb begin
        ma_src   = char_start ? crtc_ma : ma_p0;
        ld_bmp   = vld_p1 ? bmp_p1 : 8'd0;
        ld_attr  = vld_p1 ? attr_p1 : 8'd0;
        ld_en    = vld_p1 & en_p1;
        ld_cur   = vld_p1 & cur_p1;
        eff_bmp  = char_start ? ld_bmp  : shift_p2;
        eff_attr = char_start ? ld_attr : attr_p2;
        eff_en   = char_start ? ld_en   : en_p2;
        eff_cur  = char_start ? ld_cur  : cur_p2;
    end

    // p0: fetch context and memory strobes, aligned with the FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_en   <= 1'b0;
            vram_addr <= '0;
            font_en   <= 1'b0;
            font_addr <= '0;
            ma_p0     <= '0;
            ra_p0     <= '0;
            en_p0     <= 1'b0;
            cur_p0    <= 1'b0;
            attr_p0   <= '0;
            overrun   <= 1'b0;
        end else begin
            vram_en <= (state_next == RD_CHAR) || (state_next == RD_ATTR);
            font_en <= (state_next == RD_FONT);
            if (state_next == RD_CHAR)
                vram_addr <= ADDR_WIDTH'({ma_src, 1'b0});
            else if (state_next == RD_ATTR)
                vram_addr <= ADDR_WIDTH'({ma_p0, 1'b1});
            // entering RD_FONT, vram_data carries the character byte
            if (state_next == RD_FONT)
                font_addr <= {vram_data, ra_p0};
            if (char_start) begin
                ma_p0  <= crtc_ma;
                ra_p0  <= crtc_ra[2:0];
                en_p0  <= display_en;
                cur_p0 <= cursor;
            end
            if (state == RD_FONT)
                attr_p0 <= vram_data;
            if (char_start && (state != IDLE))
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    // p1: pending character buffer; p2: character on display
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bmp_p1    <= '0;
            attr_p1   <= '0;
            en_p1     <= 1'b0;
            cur_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            shift_p2  <= '0;
            attr_p2   <= '0;
            en_p2     <= 1'b0;
            cur_p2    <= 1'b0;
            pix_color <= '0;
        end else begin
            if (state == CAPTURE) begin
                bmp_p1  <= font_data;
                attr_p1 <= attr_p0;
                en_p1   <= en_p0;
                cur_p1  <= cur_p0;
                vld_p1  <= 1'b1;
            end
            if (char_start) begin
                vld_p1  <= 1'b0;
                attr_p2 <= ld_attr;
                en_p2   <= ld_en;
                cur_p2  <= ld_cur;
            end
            if (pixel_ce) begin
                pix_color <= pixel_color(eff_bmp[7], eff_cur, eff_attr, eff_en,
                                         blink_en, blink_phase);
                shift_p2  <= {eff_bmp[6:0], 1'b0};
            end else if (char_start) begin
                shift_p2  <= ld_bmp;
            end
        end
    end

endmodule

// File: doc/cga_text_fetch.md
# cga_text_fetch

Text-mode character fetch and pixel serializer for the CGA video path. It sits directly downstream of the dual-port video RAM and drives its display-side port: per CRTC character period it reads the character and attribute bytes, looks up the glyph row in an external font ROM and serializes 8 pixels into 4-bit colour indices for the palette/DAC stage. One character of pipeline latency, double-buffered so the fetch of character N overlaps the display of character N-1.

## Interface
- ADDR_WIDTH, 15, VRAM byte-address width (32 KB).
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- char_start  in  1  one-cycle pulse from CRTC at start of each character period; crtc_ma/crtc_ra/display_en/cursor valid this cycle.
- crtc_ma  in  14  CRTC word (character) address.
- crtc_ra  in  5  CRTC row address; bits [2:0] used as glyph row.
- display_en  in  1  CRTC active-display flag for this character.
- cursor  in  1  cursor active on this character/row.
- blink_en  in  1  1: attr[7] is blink; 0: attr[7] is background intensity.
- blink_phase  in  1  blink timer phase (1 = blinking characters hidden).
- pixel_ce  in  1  pixel clock enable; one pixel per asserted cycle.
- vram_en  out  1  read enable to VRAM display port (write enable tied low externally).
- vram_addr  out  ADDR_WIDTH  VRAM byte address.
- vram_data  in  8  VRAM read data; registered, valid the cycle after vram_en.
- font_en  out  1  font ROM read enable.
- font_addr  out  11  {char[7:0], crtc_ra[2:0]}.
- font_data  in  8  font ROM data; registered, valid the cycle after font_en; bit 7 = leftmost pixel.
- pix_color  out  4  registered pixel colour index.
- overrun  out  1  sticky: char_start arrived while fetch busy.
- overrun_clr  in  1  synchronous clear of overrun.

## Operation
- Fetch FSM states: IDLE, RD_CHAR, RD_ATTR, RD_FONT, CAPTURE.
- char_start (any state): latch ma, ra[2:0], display_en, cursor into fetch context; next state RD_CHAR.
- RD_CHAR: vram_en=1, vram_addr={ma,1'b0}.
- RD_ATTR: capture vram_data as char; vram_en=1, vram_addr={ma,1'b1}.
- RD_FONT: capture vram_data as attr; font_en=1, font_addr={char,ra}.
- CAPTURE: font_data -> pending bitmap; pending attr/display_en/cursor written; pending_valid=1; -> IDLE.
- vram_en/font_en are 0 in all other states; vram_addr/font_addr hold last value.
- Load on char_start: shifter <= pending bitmap, attr_q/en_q/cur_q <= pending fields, pending_valid cleared. If pending_valid=0, load bitmap 0, attr 0, en_q 0.
- Overrun: char_start while state != IDLE -> overrun=1, load as pending_valid=0 (blank), fetch restarts for new ma. overrun_clr clears; simultaneous set wins.
- Pixel compute from bit b = current shifter MSB: bit_on = b | cur_q; if blink_en & attr_q[7] & blink_phase then bit_on = cur_q. fg = attr_q[3:0]; bg = blink_en ? {1'b0,attr_q[6:4]} : attr_q[7:4]. color = en_q ? (bit_on ? fg : bg) : 0.
- On pixel_ce: pix_color <= color; shifter <<= 1 (zero fill). Holds otherwise.
- char_start and pixel_ce same cycle: pix_color computed from loaded bitmap bit 7 and loaded fields; shifter <= loaded bitmap << 1.
- More than 8 pixel_ce in a character period: output bg colour (shifted-out zeros, cursor still forces fg).

## Timing
- Reset: FSM IDLE, vram_en=0, vram_addr=0, font_en=0, font_addr=0, pix_color=0, overrun=0, pending_valid=0, shifter/attr_q/en_q/cur_q=0.
- char_start at cycle 0: RD_CHAR cycle 1, RD_ATTR cycle 2, RD_FONT cycle 3, CAPTURE cycle 4, pending valid from cycle 5.
- Minimum char_start spacing: 5 cycles; less sets overrun.
- Display latency: char N's pixels begin at char N+1's char_start; first character after reset is blank.
- pix_color updates one cycle after the enabling pixel_ce edge (registered).
- reset_n asserted mid-fetch: all state cleared immediately; no vram_en pulse after release until char_start.

## Test plan
- Reset: hold reset_n low mid-fetch -> all outputs 0, FSM IDLE; release, no vram_en until char_start.
- Fetch sequence: char_start ma=0x0123, ra=3 -> vram_addr 0x0246 (cycle 1), 0x0247 (cycle 2), font_addr={char,3'd3} (cycle 3), single-cycle enables.
- Serialize: char 0x41, attr 0x1E, font 0xA5, display_en=1, 8 pixel_ce after next char_start -> pix_color E,1,E,1,1,E,1,E.
- Blink/cursor: attr 0x9E, blink_en=1, blink_phase=1 -> all pixels 1; cursor=1 -> all pixels E; blink_en=0 -> bg = 9.
- Blanking: display_en=0 with font 0xFF -> pix_color 0 for all 8 pixels.
- Overrun: char_start spaced 3 cycles -> overrun=1, next character blank; overrun_clr -> 0; 5-cycle spacing -> no overrun.
